// File: rtl/game_match_ctrl.sv
// Match controller: scores points per player, declares a winner, holds OVER for HOLD_MS ticks.
// Optional build macro GAME_MATCH_WIN_BY_TWO_EN: a win also needs a 2-point lead (saturated score always wins).
module game_match_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 5,
    parameter int HOLD_MS     = 3000,
    localparam int PW         = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int HW         = $clog2(HOLD_MS + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick_1ms,
    input  logic                           start,
    input  logic                           point_valid,
    input  logic [PW-1:0]                  point_player,
    output logic                           point_ready,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [1:0]                     state,
    output logic [PW-1:0]                  winner,
    output logic                           winner_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    localparam logic [SCORE_W-1:0]             MAX_SCORE   = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0]             WIN_L       = SCORE_W'(WIN_SCORE);
    localparam logic [PW:0]                    NP_L        = (PW + 1)'(NUM_PLAYERS);
    localparam logic [HW-1:0]                  HOLD_LAST   = HW'(HOLD_MS - 1);
    localparam logic [NUM_PLAYERS*SCORE_W-1:0] ZERO_SCORES = {(NUM_PLAYERS*SCORE_W){1'b0}};

    state_e              state_r;
    logic [HW-1:0]       hold_r;
    logic [SCORE_W-1:0]  cur_s;
    logic [SCORE_W-1:0]  inc_s;
    logic                valid_player_s;
    logic                accept_s;
    logic                win_s;

    assign state = state_r;

    // Post-increment score of the offered player and the win decision on it.
    always_comb begin
        cur_s = {SCORE_W{1'b0}};
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            cur_s = (PW'(i) == point_player) ? scores[i*SCORE_W +: SCORE_W] : cur_s;
        end
        inc_s          = (cur_s == MAX_SCORE) ? cur_s : cur_s + SCORE_W'(1);
        valid_player_s = ({1'b0, point_player} < NP_L);
        // A restart in the same cycle wins over any offered point.
        accept_s       = point_ready & point_valid & ~start & valid_player_s;
`ifdef GAME_MATCH_WIN_BY_TWO_EN
        win_s = (inc_s >= WIN_L);
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            win_s = win_s & ~((PW'(j) != point_player) &&
                    (({1'b0, scores[j*SCORE_W +: SCORE_W]} + (SCORE_W + 1)'(2)) > {1'b0, inc_s}));
        end
        win_s = win_s | (inc_s == MAX_SCORE);
`else
        win_s = (inc_s >= WIN_L);
`endif
    end

    // Match state machine with registered scores, winner flags and hold counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            scores       <= ZERO_SCORES;
            winner       <= {PW{1'b0}};
            winner_valid <= 1'b0;
            point_ready  <= 1'b0;
            hold_r       <= {HW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r     <= ST_PLAY;
                        scores      <= ZERO_SCORES;
                        point_ready <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (start) begin
                        scores <= ZERO_SCORES;
                    end else if (accept_s) begin
                        scores[point_player*SCORE_W +: SCORE_W] <= inc_s;
                        if (win_s) begin
                            state_r      <= ST_OVER;
                            winner       <= point_player;
                            winner_valid <= 1'b1;
                            point_ready  <= 1'b0;
                            hold_r       <= {HW{1'b0}};
                        end else begin
                            state_r      <= ST_PLAY;
                        end
                    end else begin
                        state_r <= ST_PLAY;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state_r      <= ST_PLAY;
                        scores       <= ZERO_SCORES;
                        winner       <= {PW{1'b0}};
                        winner_valid <= 1'b0;
                        point_ready  <= 1'b1;
                        hold_r       <= {HW{1'b0}};
                    end else if (tick_1ms) begin
                        if (hold_r == HOLD_LAST) begin
                            state_r      <= ST_IDLE;
                            scores       <= ZERO_SCORES;
                            winner       <= {PW{1'b0}};
                            winner_valid <= 1'b0;
                            hold_r       <= {HW{1'b0}};
                        end else begin
                            hold_r       <= hold_r + HW'(1);
                        end
                    end else begin
                        state_r <= ST_OVER;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    scores       <= ZERO_SCORES;
                    winner       <= {PW{1'b0}};
                    winner_valid <= 1'b0;
                    point_ready  <= 1'b0;
                    hold_r       <= {HW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_match_ctrl.sv
// Bench for game_match_ctrl (3 players): per-cycle comparison against a behavioural match model plus literal checks.
module tb_game_match_ctrl;

    localparam int NP   = 3;
    localparam int SW   = 4;
    localparam int WIN  = 5;
    localparam int HOLD = 3000;
    localparam int MAXS = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tick_1ms = 1'b0;
    logic          start = 1'b0;
    logic          point_valid = 1'b0;
    logic [1:0]    point_player = 2'd0;
    logic          point_ready;
    logic [NP*SW-1:0] scores;
    logic [1:0]    state;
    logic [1:0]    winner;
    logic          winner_valid;

    int total = 0;
    int bad   = 0;

    int m_score [NP];
    int m_state  = 0;
    int m_winner = 0;
    int m_hold   = 0;

    game_match_ctrl #(.NUM_PLAYERS(NP), .SCORE_W(SW), .WIN_SCORE(WIN), .HOLD_MS(HOLD)) dut (
        .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .start(start),
        .point_valid(point_valid), .point_player(point_player),
        .point_ready(point_ready), .scores(scores), .state(state),
        .winner(winner), .winner_valid(winner_valid)
    );

    always #5 clk = ~clk;

    function automatic bit m_wins(int p);
        int s;
        s = m_score[p];
`ifdef GAME_MATCH_WIN_BY_TWO_EN
        if (s == MAXS) return 1'b1;
        if (s < WIN) return 1'b0;
        for (int j = 0; j < NP; j++)
            if (j != p && s - m_score[j] < 2) return 1'b0;
        return 1'b1;
`else
        return s >= WIN;
`endif
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NP; i++) m_score[i] = 0;
    endtask

    task automatic m_step(bit rs, bit st, bit pv, int pp, bit tk);
        if (!rs) begin
            m_clear(); m_state = 0; m_winner = 0; m_hold = 0;
        end else begin
            case (m_state)
                0: if (st) begin m_state = 1; m_clear(); end
                1: begin
                    if (st) m_clear();
                    else if (pv && pp < NP) begin
                        if (m_score[pp] < MAXS) m_score[pp]++;
                        if (m_wins(pp)) begin m_state = 2; m_winner = pp; m_hold = 0; end
                    end
                end
                2: begin
                    if (st) begin m_state = 1; m_clear(); m_hold = 0; end
                    else if (tk) begin
                        m_hold++;
                        if (m_hold == HOLD) begin m_state = 0; m_clear(); m_hold = 0; end
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic check(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int sc(int p);
        return int'(scores[p*SW +: SW]);
    endfunction

    task automatic cyc(bit rs, bit st, bit pv, int pp, bit tk);
        reset = rs; start = st; point_valid = pv; point_player = pp[1:0]; tick_1ms = tk;
        m_step(rs, st, pv, pp, tk);
        @(posedge clk);
        #1;
        check("model_state", int'(state), m_state);
        check("model_ready", int'(point_ready), int'(m_state == 1));
        check("model_wvalid", int'(winner_valid), int'(m_state == 2));
        for (int i = 0; i < NP; i++) check("model_score", sc(i), m_score[i]);
        if (m_state == 2) check("model_winner", int'(winner), m_winner);
    endtask

    task automatic pt(int p);
        cyc(1'b1, 1'b0, 1'b1, p, 1'b0);
    endtask

    task automatic ticks(int n, bit pv);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, pv, 0, 1'b1);
    endtask

    initial begin
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1, 1'b1);
        check("rst_state", int'(state), 0);
        check("rst_scores", int'(scores), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_wvalid", int'(winner_valid), 0);
        check("rst_ready", int'(point_ready), 0);

        cyc(1'b1, 1'b0, 1'b0, 0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
        check("start_state", int'(state), 1);
        check("start_scores", int'(scores), 0);
        check("start_ready", int'(point_ready), 1);

        for (int k = 0; k < 5; k++) begin
            pt(1);
            cyc(1'b1, 1'b0, 1'b0, 0, 1'b1);
        end
        check("win_state", int'(state), 2);
        check("win_winner", int'(winner), 1);
        check("win_wvalid", int'(winner_valid), 1);
        check("win_p1", sc(1), 5);

        ticks(HOLD - 2, 1'b1);
        check("hold_state", int'(state), 2);
        check("hold_p1", sc(1), 5);
        check("hold_p0", sc(0), 0);
        ticks(1, 1'b1);
        check("expire_state", int'(state), 0);
        check("expire_scores", int'(scores), 0);
        check("expire_wvalid", int'(winner_valid), 0);

        cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
        pt(0); pt(0);
        cyc(1'b1, 1'b1, 1'b1, 0, 1'b0);
        check("restart_scores", int'(scores), 0);
        check("restart_state", int'(state), 1);
        pt(3);
        check("bad_player_scores", int'(scores), 0);
        pt(2);
        check("p2_score", sc(2), 1);
        cyc(1'b0, 1'b1, 1'b1, 2, 1'b1);
        check("midrst_state", int'(state), 0);
        check("midrst_scores", int'(scores), 0);

        cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin pt(0); pt(1); end
        check("tie_p0", sc(0), 4);
        check("tie_p1", sc(1), 4);
        pt(0);
        check("five_four_p0", sc(0), 5);
`ifdef GAME_MATCH_WIN_BY_TWO_EN
        check("five_four_state", int'(state), 1);
        pt(0);
        check("six_four_p0", sc(0), 6);
        check("six_four_state", int'(state), 2);
        check("six_four_winner", int'(winner), 0);
`else
        check("five_four_state", int'(state), 2);
        check("five_four_winner", int'(winner), 0);
`endif

        ticks(100, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
        check("over_start_state", int'(state), 1);
        check("over_start_scores", int'(scores), 0);
        for (int k = 0; k < 5; k++) pt(2);
        check("p2_win_winner", int'(winner), 2);
        ticks(HOLD - 1, 1'b0);
        check("hold_cleared_state", int'(state), 2);
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b1);
        check("start_priority_state", int'(state), 1);

        for (int k = 0; k < 5; k++) pt(0);
        check("p0_win_state", int'(state), 2);
        ticks(7, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 0, 1'b1);
        check("over_rst_state", int'(state), 0);
        check("over_rst_wvalid", int'(winner_valid), 0);
        check("over_rst_scores", int'(scores), 0);
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
